// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle main control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with a memory-ready watchdog and opcode trap.
module riscv_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCSrc,
    output logic       pc_en,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       mem_timeout,
    output logic [3:0] state_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_ALU_WB   = 4'd9,
        S_ERROR    = 4'd15
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       pc_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
    } ctl_t;

    // Pure Moore decode; registered against the next state so it lines up with r_state.
    function automatic ctl_t moore(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.mem_read = 1'b1; c.src_b = 2'b01; end
            S_DECODE:   c.src_b = 2'b10;
            S_EXEC_R:   begin c.src_a = 1'b1; c.alu_op = 2'b10; end
            S_EXEC_I:   begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu_op = 2'b10; end
            S_MEM_ADDR: begin c.src_a = 1'b1; c.src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_req = 1'b1; c.mem_read = 1'b1; c.iord = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.retire = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.iord = 1'b1; end
            S_BRANCH:   begin c.src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 1'b1; c.retire = 1'b1; end
            S_ALU_WB:   begin c.reg_write = 1'b1; c.retire = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    state_t          r_state;
    state_t          w_next;
    ctl_t            r_ctl;
    logic [CW-1:0]   r_cnt;
    logic            r_illegal;
    logic            r_timeout;
    logic            w_waiting;
    logic            w_limit;
    logic            w_run;

    always_comb begin
        w_waiting = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
        w_limit   = w_waiting && !mem_ready && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
        w_next    = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
                    OP_LW, OP_SW: w_next = S_MEM_ADDR;
                    OP_BR:        w_next = S_BRANCH;
                    default:      w_next = S_ERROR;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_MEM_ADDR: w_next = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_MEM_WB, S_ALU_WB, S_BRANCH: w_next = S_FETCH;
            default:    w_next = S_ERROR;
        endcase
        // A ready on the limit cycle takes the normal path; only a missing ready traps.
        if (w_limit) w_next = S_ERROR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_ctl     <= moore(S_FETCH);
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctl   <= moore(w_next);
            r_cnt   <= (w_waiting && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
            if ((r_state == S_DECODE) && (w_next == S_ERROR)) r_illegal <= 1'b1;
            if (w_limit) r_timeout <= 1'b1;
        end
    end

    // Reset is synchronous, so outputs are gated to keep every strobe low during it.
    assign w_run         = ~reset;
    assign mem_req       = w_run & r_ctl.mem_req;
    assign IorD          = w_run & r_ctl.iord;
    assign MemRead       = w_run & r_ctl.mem_read;
    assign MemWrite      = w_run & r_ctl.mem_write;
    assign IRWrite       = w_run & (r_state == S_FETCH) & mem_ready;
    assign ALUSrcA       = w_run & r_ctl.src_a;
    assign ALUSrcB       = {2{w_run}} & r_ctl.src_b;
    assign ALUOp         = {2{w_run}} & r_ctl.alu_op;
    assign PCSrc         = w_run & r_ctl.pc_src;
    assign pc_en         = w_run & (((r_state == S_FETCH) & mem_ready) | ((r_state == S_BRANCH) & Zero));
    assign MemtoReg      = w_run & r_ctl.mem_to_reg;
    assign RegWrite      = w_run & r_ctl.reg_write;
    assign instr_retired = w_run & (r_ctl.retire | ((r_state == S_MEM_WR) & mem_ready));
    assign illegal_instr = w_run & r_illegal;
    assign mem_timeout   = w_run & r_timeout;
    assign state_o       = w_run ? 4'(r_state) : 4'd0;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Randomized bench: instruction-level phase model expands each instruction into
// expected per-cycle states/controls, then drives and compares cycle by cycle.
module tb_riscv_multicycle_ctrl;
    localparam int T = 8;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] Opcode = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic       PCSrc, pc_en, MemtoReg, RegWrite, instr_retired;
    logic       illegal_instr, mem_timeout;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .pc_en(pc_en), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    typedef struct {
        logic        rst;
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        ill;
        logic        tmo;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] cv(input logic mreq, iord, mrd, mwr, irw, sa,
                                       input logic [1:0] sb, aop,
                                       input logic pcs, pce, m2r, rw, ret);
        return {mreq, iord, mrd, mwr, irw, sa, sb, aop, pcs, pce, m2r, rw, ret};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op == OP_R || op == OP_I || op == OP_LW || op == OP_SW || op == OP_BR;
    endfunction

    task automatic add(input logic rst, mr, z, input logic [6:0] op, input logic [3:0] st,
                       input logic [14:0] ctl, input logic ill, tmo);
        ent_t e;
        e.rst = rst; e.mr = mr; e.z = z; e.op = op;
        e.st = st; e.ctl = ctl; e.ill = ill; e.tmo = tmo;
        q.push_back(e);
    endtask

    task automatic g_reset(input logic mr);
        add(1'b1, mr, rb(), rop(), 4'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic g_error(input int n, input logic ill, tmo, input logic [6:0] op);
        for (int i = 0; i < n; i++) add(1'b0, rb(), rb(), op, 4'd15, '0, ill, tmo);
        g_reset(rb());
    endtask

    // Fetch with fw not-ready cycles; fw >= T means the watchdog fires instead.
    task automatic g_fetch(input int fw, output bit ok);
        int lim = (fw >= T) ? T : fw;
        for (int i = 0; i < lim; i++)
            add(1'b0, 1'b0, rb(), rop(), 4'd0, cv(1,0,1,0,0,0,2'b01,2'b00,0,0,0,0,0), 1'b0, 1'b0);
        if (fw >= T) begin
            g_error($urandom_range(1, 4), 1'b0, 1'b1, rop());
            ok = 1'b0;
        end else begin
            add(1'b0, 1'b1, rb(), rop(), 4'd0, cv(1,0,1,0,1,0,2'b01,2'b00,0,1,0,0,0), 1'b0, 1'b0);
            ok = 1'b1;
        end
    endtask

    task automatic g_mem(input logic [6:0] op, input int dw);
        logic        is_lw = (op == OP_LW);
        logic [3:0]  st    = is_lw ? 4'd5 : 4'd7;
        logic [14:0] cw    = is_lw ? cv(1,1,1,0,0,0,2'b00,2'b00,0,0,0,0,0)
                                   : cv(1,1,0,1,0,0,2'b00,2'b00,0,0,0,0,0);
        int          lim   = (dw >= T) ? T : dw;
        for (int i = 0; i < lim; i++) add(1'b0, 1'b0, rb(), op, st, cw, 1'b0, 1'b0);
        if (dw >= T) begin
            g_error($urandom_range(1, 4), 1'b0, 1'b1, op);
        end else if (is_lw) begin
            add(1'b0, 1'b1, rb(), op, st, cw, 1'b0, 1'b0);
            add(1'b0, rb(), rb(), op, 4'd6, cv(0,0,0,0,0,0,2'b00,2'b00,0,0,1,1,1), 1'b0, 1'b0);
        end else begin
            add(1'b0, 1'b1, rb(), op, st, cw | 15'd1, 1'b0, 1'b0);
        end
    endtask

    task automatic g_instr(input logic [6:0] op, input int fw, dw, input logic z);
        bit ok;
        g_fetch(fw, ok);
        if (!ok) return;
        add(1'b0, rb(), rb(), op, 4'd1, cv(0,0,0,0,0,0,2'b10,2'b00,0,0,0,0,0), 1'b0, 1'b0);
        case (op)
            OP_R, OP_I: begin
                add(1'b0, rb(), rb(), op, (op == OP_R) ? 4'd2 : 4'd3,
                    cv(0,0,0,0,0,1,(op == OP_R) ? 2'b00 : 2'b10,2'b10,0,0,0,0,0), 1'b0, 1'b0);
                add(1'b0, rb(), rb(), op, 4'd9, cv(0,0,0,0,0,0,2'b00,2'b00,0,0,0,1,1), 1'b0, 1'b0);
            end
            OP_LW, OP_SW: begin
                add(1'b0, rb(), rb(), op, 4'd4, cv(0,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0), 1'b0, 1'b0);
                g_mem(op, dw);
            end
            OP_BR:
                add(1'b0, rb(), z, op, 4'd8, cv(0,0,0,0,0,1,2'b00,2'b01,1,z,0,0,1), 1'b0, 1'b0);
            default:
                g_error($urandom_range(21, 24), 1'b1, 1'b0, op);
        endcase
    endtask

    // sw stalled in MEM_WR, then reset arrives while the memory claims ready.
    task automatic g_sw_abort(input int k);
        bit ok;
        g_fetch(0, ok);
        add(1'b0, rb(), rb(), OP_SW, 4'd1, cv(0,0,0,0,0,0,2'b10,2'b00,0,0,0,0,0), 1'b0, 1'b0);
        add(1'b0, rb(), rb(), OP_SW, 4'd4, cv(0,0,0,0,0,1,2'b10,2'b00,0,0,0,0,0), 1'b0, 1'b0);
        for (int i = 0; i < k; i++)
            add(1'b0, 1'b0, rb(), OP_SW, 4'd7, cv(1,1,0,1,0,0,2'b00,2'b00,0,0,0,0,0), 1'b0, 1'b0);
        g_reset(1'b1);
    endtask

    function automatic int rwait();
        int r = $urandom_range(0, 19);
        if (r == 0) return T;
        if (r == 1) return T - 1;
        return $urandom_range(0, 2);
    endfunction

    initial begin
        logic [6:0] op;
        g_reset(1'b0);
        g_reset(1'b1);
        g_instr(OP_R, 0, 0, 1'b0);
        g_instr(OP_LW, 0, 3, 1'b0);
        g_instr(OP_BR, 0, 0, 1'b1);
        g_instr(OP_BR, 0, 0, 1'b0);
        g_instr(7'b1111111, 0, 0, 1'b0);
        g_instr(OP_R, T, 0, 1'b0);
        g_instr(OP_R, T - 1, 0, 1'b0);
        g_instr(OP_SW, 0, T - 1, 1'b0);
        g_instr(OP_LW, 1, T, 1'b0);
        g_sw_abort(2);
        g_instr(OP_I, 0, 0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1: op = OP_R;
                2:    op = OP_I;
                3, 4: op = OP_LW;
                5, 6: op = OP_SW;
                7, 8: op = OP_BR;
                default: begin
                    op = rop();
                    while (legal(op)) op = rop();
                end
            endcase
            if ($urandom_range(0, 29) == 0) g_reset(rb());
            if ($urandom_range(0, 29) == 0) g_sw_abort($urandom_range(0, T - 2));
            else g_instr(op, rwait(), rwait(), rb());
        end

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = q[i].rst;
            mem_ready = q[i].mr;
            Zero      = q[i].z;
            Opcode    = q[i].op;
            @(negedge clk);
            chk($sformatf("c%0d state", i), 32'(state_o), 32'(q[i].st));
            chk($sformatf("c%0d ctl", i),
                32'({mem_req, IorD, MemRead, MemWrite, IRWrite, ALUSrcA, ALUSrcB, ALUOp,
                     PCSrc, pc_en, MemtoReg, RegWrite, instr_retired}),
                32'(q[i].ctl));
            chk($sformatf("c%0d flags", i), 32'({illegal_instr, mem_timeout}),
                32'({q[i].ill, q[i].tmo}));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multicycle main control FSM for the RISC-V core. Sequences fetch, decode, execute, memory and writeback over several cycles so one ALU and one unified memory port are shared by all phases.
- Drives the datapath mux selects, write enables and ALUOp, using the same ALUOp encoding as the single-cycle decoder.
- Adds a ready handshake with the memory port, a memory timeout watchdog and illegal-opcode trapping.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ready in one access before trapping. Legal range is 2..65535. The counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  7  instruction[6:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request, held until mem_ready.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read.
- MemWrite  out  1  memory write.
- IRWrite  out  1  load the instruction register.
- ALUSrcA  out  1  ALU operand A select: 0 = PC, 1 = rs1.
- ALUSrcB  out  2  ALU operand B select: 00 = rs2, 01 = constant 4, 10 = immediate, 11 unused.
- ALUOp  out  2  00 = add (address/PC), 01 = branch compare, 10 = R/I function decode.
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- pc_en  out  1  PC write enable.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = memory data register.
- RegWrite  out  1  register file write.
- instr_retired  out  1  one-cycle pulse when an instruction completes.
- illegal_instr  out  1  sticky: unsupported opcode decoded.
- mem_timeout  out  1  sticky: memory access exceeded TIMEOUT_CYCLES.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and reset.
- While reset is high: state = FETCH (0), wait counter = 0, sticky flags = 0, and every output is forced to 0. The first FETCH cycle is the first cycle with reset low.
- Reset asserted in any state, including mid memory wait, aborts the instruction. No write enable may assert in that cycle.
- All outputs are Moore outputs of the state, except pc_en in BRANCH and the mem_ready-qualified strobes listed below.
- Unlisted outputs are 0 in each state.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, BRANCH 8, ALU_WB 9, ERROR 15.
- FETCH:
  - Outputs: mem_req = 1, MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 0.
  - IRWrite = pc_en = mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut).
  - Next state by Opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 -> BRANCH
    - any other value -> ERROR
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next ALU_WB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10. Next ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0, instr_retired = 1. Next FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next MEM_RD if Opcode = 0000011, otherwise MEM_WR. Opcode is stable because IR is held.
- MEM_RD: mem_req = 1, MemRead = 1, IorD = 1. On mem_ready go to MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, instr_retired = 1. Next FETCH.
- MEM_WR:
  - Outputs: mem_req = 1, MemWrite = 1, IorD = 1.
  - instr_retired = mem_ready.
  - On mem_ready go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 1, instr_retired = 1.
  - pc_en = Zero.
  - Next FETCH.
- ERROR:
  - All controls 0; illegal_instr or mem_timeout is held high.
  - Remains in ERROR until reset.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR, and whenever mem_ready is seen.
  - Increments each cycle spent in a waiting state without mem_ready.
  - If the counter equals TIMEOUT_CYCLES-1 and mem_ready is still 0: go to ERROR and set mem_timeout. mem_req drops the next cycle.
  - mem_ready in the same cycle as the limit wins: normal transition, no timeout.
- Minimum latencies with zero-wait memory:
  - R/I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.

Test Plan:
- R-type add, Opcode = 0110011, mem_ready tied 1 -> states 0,1,2,9,0. RegWrite high only in cycle 4. instr_retired pulses once. IRWrite and pc_en high in cycle 1.
- lw, Opcode = 0000011, fetch ready immediate, data mem_ready after 3 wait cycles -> sequence 0,1,4,5,5,5,5,6. RegWrite = MemtoReg = 1 only in state 6. MemRead = IorD = 1 for all 4 MEM_RD cycles.
- beq, Opcode = 1100011: with Zero = 1 -> pc_en = 1 and PCSrc = 1 in BRANCH; with Zero = 0 -> pc_en = 0. Both cases return to FETCH after 3 cycles.
- Opcode = 1111111 -> ERROR after DECODE. illegal_instr = 1, state_o = 15, all controls 0 for 20+ cycles. reset clears it to FETCH.
- TIMEOUT_CYCLES = 8, mem_ready held 0 in FETCH -> 8 cycles in FETCH, then ERROR with mem_timeout = 1. A second run with mem_ready on the 8th cycle -> DECODE, no flag.
- sw stalled in MEM_WR with reset asserted for 1 cycle -> MemWrite = 0 in the reset cycle and FETCH on the next cycle. No instr_retired pulse.
